// File: rtl/bus_loader.sv
// Byte-command bus master: serial read/write commands drive a 16-bit address bus.
// Reads stream data back over the tx handshake; writes end with an 0x4B acknowledge.
module bus_loader #(
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned RX_TIMEOUT = 20800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [15:0] o_address,
  output logic [7:0]  o_dout,
  input  logic [7:0]  i_din,
  output logic        o_read,
  output logic        o_active,
  output logic        o_overrun
);

  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RX_TIMEOUT - 1);
  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_GET_AH  = 4'd1;
  localparam logic [3:0] S_GET_AL  = 4'd2;
  localparam logic [3:0] S_GET_N   = 4'd3;
  localparam logic [3:0] S_GET_D   = 4'd4;
  localparam logic [3:0] S_WR      = 4'd5;
  localparam logic [3:0] S_RD_WAIT = 4'd6;
  localparam logic [3:0] S_RD_SEND = 4'd7;
  localparam logic [3:0] S_ACK     = 4'd8;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  logic [3:0]    r_state;
  logic          r_is_write;
  logic [15:0]   r_addr;
  logic [7:0]    r_dout;
  logic [7:0]    r_cnt;
  logic [3:0]    r_wait;
  logic [TW-1:0] r_to;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_overrun;

  logic w_rx_get;
  logic w_busy;
  logic w_hs;
  logic w_to_hit;

  assign w_rx_get = (r_state == S_GET_AH) || (r_state == S_GET_AL) ||
                    (r_state == S_GET_N)  || (r_state == S_GET_D);
  assign w_busy   = (r_state == S_WR) || (r_state == S_RD_WAIT) ||
                    (r_state == S_RD_SEND) || (r_state == S_ACK);
  assign w_hs     = r_tx_valid & i_tx_ready;
  assign w_to_hit = (r_to == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_addr     <= 16'h0000;
      r_dout     <= 8'h00;
      r_cnt      <= 8'h00;
      r_wait     <= 4'h0;
      r_to       <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // Bytes arriving while the bus side is busy are dropped, not queued.
      r_overrun <= i_rx_valid & w_busy;

      if (w_rx_get && !i_rx_valid) r_to <= r_to + TW'(1);
      else                         r_to <= '0;

      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && (i_rx_data == OP_READ || i_rx_data == OP_WRITE)) begin
            r_is_write <= (i_rx_data == OP_WRITE);
            r_state    <= S_GET_AH;
          end
        end
        S_GET_AH: begin
          if (i_rx_valid) begin
            r_addr[15:8] <= i_rx_data;
            r_state      <= S_GET_AL;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_AL: begin
          if (i_rx_valid) begin
            r_addr[7:0] <= i_rx_data;
            r_state     <= S_GET_N;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_N: begin
          if (i_rx_valid) begin
            r_cnt   <= i_rx_data;
            r_wait  <= 4'h0;
            r_state <= r_is_write ? S_GET_D : S_RD_WAIT;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_D: begin
          if (i_rx_valid) begin
            r_dout  <= i_rx_data;
            r_state <= S_WR;
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_WR: begin
          if (r_cnt == 8'h00) begin
            r_tx_data  <= ACK_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= S_ACK;
          end else begin
            r_cnt   <= r_cnt - 8'h01;
            r_addr  <= r_addr + 16'h0001;
            r_state <= S_GET_D;
          end
        end
        S_RD_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_tx_data  <= i_din;
            r_tx_valid <= 1'b1;
            r_wait     <= 4'h0;
            r_state    <= S_RD_SEND;
          end else begin
            r_wait <= r_wait + 4'h1;
          end
        end
        S_RD_SEND: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            if (r_cnt == 8'h00) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'h01;
              r_addr  <= r_addr + 16'h0001;
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_ACK: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_address  = r_addr;
  assign o_dout     = r_dout;
  assign o_read     = (r_state != S_WR);
  assign o_active   = (r_state != S_IDLE);
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_bus_loader.sv
// Directed bench for bus_loader: stimulus pushes expected bus writes / tx bytes into
// queues, and a negedge monitor pops and compares whenever the DUT presents them.
module tb_bus_loader;

  localparam int unsigned RW = 2;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] address;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        rd;
  logic        active;
  logic        overrun;

  logic [7:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovr = 0;
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_tx[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_wr    = 1'b0;

  always #5 clk = ~clk;
  assign din = mem[address];

  bus_loader #(.READ_WAIT(RW), .RX_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_address(address), .o_dout(dout), .i_din(din), .o_read(rd),
    .o_active(active), .o_overrun(overrun)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endfunction

  // Monitor: bus write strobes, tx handshakes, overrun pulses, tx hold stability.
  always @(negedge clk) begin
    logic [23:0] e;
    if (!rd) begin
      if (exp_wr.size() == 0) fail_now("wr_unexpected");
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", {16'h0, address}, {16'h0, e[23:8]});
        check("wr_data", {24'h0, dout}, {24'h0, e[7:0]});
      end
      check("wr_single_cycle", {31'h0, prev_wr}, 32'h0);
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) fail_now("tx_unexpected");
      else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
    end
    if (prev_stall && rst_n) begin
      check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
      check("tx_hold_data", {24'h0, tx_data}, {24'h0, prev_data});
    end
    if (overrun) begin
      if (exp_ovr == 0) fail_now("overrun_unexpected");
      else exp_ovr--;
    end
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
    prev_wr    <= !rd;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] n);
    send_byte(op);     gap(2);
    send_byte(a[15:8]); gap(2);
    send_byte(a[7:0]);  gap(2);
    send_byte(n);       gap(2);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!active) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) fail_now({nm, "_idle_timeout"});
  endtask

  task automatic wait_tx(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) fail_now({nm, "_tx_timeout"});
  endtask

  initial begin
    int bad;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    mem[16'h1234] = 8'h5A;
    mem[16'h1235] = 8'hC3;
    mem[16'hFFFF] = 8'hE1;
    mem[16'h0000] = 8'h1E;
    mem[16'h0010] = 8'h77;
    mem[16'h2000] = 8'h99;

    repeat (3) @(posedge clk);
    #1;
    check("rst_active",  {31'h0, active}, 32'h0);
    check("rst_read",    {31'h0, rd}, 32'h1);
    check("rst_address", {16'h0, address}, 32'h0);
    check("rst_dout",    {24'h0, dout}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    gap(2);

    // Two-byte write, then 0x4B acknowledge.
    exp_wr.push_back({16'h1234, 8'hAA});
    exp_wr.push_back({16'h1235, 8'hBB});
    exp_tx.push_back(8'h4B);
    send_cmd(8'h57, 16'h1234, 8'h01);
    send_byte(8'hAA); gap(3);
    send_byte(8'hBB);
    wait_idle("write");
    check("write_done_idle", {31'h0, active}, 32'h0);
    check("write_queues_empty", exp_wr.size() + exp_tx.size(), 0);

    // Two-byte read.
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hC3);
    send_cmd(8'h52, 16'h1234, 8'h01);
    wait_idle("read");
    check("read_queue_empty", exp_tx.size(), 0);

    // Read across 0xFFFF with the transmitter stalled for 50 cycles.
    tx_ready = 1'b0;
    send_cmd(8'h52, 16'hFFFF, 8'h01);
    wait_tx("wrap");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!tx_valid || tx_data !== 8'hE1) bad++;
      @(posedge clk); #1;
    end
    check("wrap_hold_stable", bad, 0);
    check("wrap_first_byte", {24'h0, tx_data}, 32'hE1);
    exp_tx.push_back(8'hE1);
    exp_tx.push_back(8'h1E);
    tx_ready = 1'b1;
    wait_idle("wrap");
    check("wrap_queue_empty", exp_tx.size(), 0);
    check("wrap_address", {16'h0, address}, 32'h0);

    // Abandoned command times out with no bus write.
    send_byte(8'h57); gap(1);
    send_byte(8'h00);
    gap(TO - 3);
    check("timeout_still_active", {31'h0, active}, 32'h1);
    gap(6);
    check("timeout_idle", {31'h0, active}, 32'h0);
    exp_tx.push_back(8'h77);
    send_cmd(8'h52, 16'h0010, 8'h00);
    wait_idle("after_timeout");
    check("after_timeout_queue", exp_tx.size(), 0);

    // Non-opcode in IDLE is ignored.
    send_byte(8'h41);
    gap(3);
    check("ignore_41_idle", {31'h0, active}, 32'h0);

    // rx byte during RD_SEND: dropped, one overrun pulse, data unchanged.
    tx_ready = 1'b0;
    send_cmd(8'h52, 16'h2000, 8'h00);
    wait_tx("ovr");
    exp_ovr = 1;
    send_byte(8'h57);
    gap(3);
    check("ovr_pulse_seen", exp_ovr, 0);
    check("ovr_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("ovr_tx_data", {24'h0, tx_data}, 32'h99);
    exp_tx.push_back(8'h99);
    tx_ready = 1'b1;
    wait_idle("ovr");
    gap(3);
    check("ovr_byte_not_opcode", {31'h0, active}, 32'h0);

    // Reset during the first WR of a four-byte write.
    exp_wr.push_back({16'h3000, 8'hD0});
    send_cmd(8'h57, 16'h3000, 8'h03);
    send_byte(8'hD0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_active", {31'h0, active}, 32'h0);
    check("mid_rst_read", {31'h0, rd}, 32'h1);
    check("mid_rst_address", {16'h0, address}, 32'h0);
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    rst_n = 1'b1;
    gap(10);
    check("mid_rst_wr_count", exp_wr.size(), 0);
    check("final_tx_queue", exp_tx.size(), 0);
    check("final_ovr", exp_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_loader.md
BUS_LOADER -- requirements
Module: bus_loader

Interface
REQ-001 Parameter READ_WAIT, default 1: clock cycles between presenting a read address and sampling din (1..15).
REQ-002 Parameter RX_TIMEOUT, default 20800: idle cycles allowed between command bytes before the partial command is abandoned (10 ms at 2.08 MHz).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; rst=0 sampled on a rising clk edge resets the block.
REQ-005 rx_data  in  8  received serial byte.
REQ-006 rx_valid  in  1  one-cycle pulse qualifying rx_data; no backpressure.
REQ-007 tx_data  out  8  byte to transmit.
REQ-008 tx_valid  out  1  tx_data valid; held until accepted.
REQ-009 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high in the same cycle.
REQ-010 address  out  16  bus address.
REQ-011 dout  out  8  bus write data.
REQ-012 din  in  8  bus read data.
REQ-013 read  out  1  bus direction; 1 = read/idle, 0 = write strobe.
REQ-014 active  out  1  high whenever state is not IDLE; the system uses it to hold off the CPU.
REQ-015 overrun  out  1  one-cycle pulse when an rx byte is dropped.

Function
REQ-016 Command set:
  - Read: 0x52, AH, AL, N; reads N+1 bytes starting at {AH,AL}.
  - Write: 0x57, AH, AL, N, D0..DN; writes N+1 bytes.
REQ-017 States: IDLE, GET_AH, GET_AL, GET_N, GET_D, WR, RD_WAIT, RD_SEND, ACK.
REQ-018 IDLE: on rx_valid, 0x52 or 0x57 latches the opcode and goes to GET_AH; any other byte is ignored silently.
REQ-019 GET_AH -> GET_AL -> GET_N, advancing one state per rx_valid. N is latched into an 8-bit counter.
REQ-020 After GET_N, a read goes to RD_WAIT and a write goes to GET_D.
REQ-021 GET_D: on rx_valid, latch the byte into dout and go to WR.
REQ-022 WR: exactly one cycle with read=0 and address/dout stable. Then:
  - if the counter is 0, go to ACK;
  - otherwise decrement the counter, increment the address, and return to GET_D.
REQ-023 RD_WAIT: read=1, address stable; after READ_WAIT cycles, capture din into tx_data, assert tx_valid, and go to RD_SEND.
REQ-024 RD_SEND: hold tx_valid until the handshake completes. Then:
  - if the counter is 0, go to IDLE;
  - otherwise decrement the counter, increment the address, and return to RD_WAIT.
REQ-025 ACK: present tx_data=0x4B with tx_valid; go to IDLE on handshake.
REQ-026 Address increment is modulo 2^16 (0xFFFF wraps to 0x0000); N=0xFF yields 256 transfers.
REQ-027 read=0 only in WR; in every other state read=1.
REQ-028 The bus address keeps its last value when idle.
REQ-029 In GET_AH, GET_AL, GET_N and GET_D, a counter of cycles without rx_valid reaching RX_TIMEOUT returns the block to IDLE with no bus write; the counter clears on every rx_valid.
REQ-030 rx_valid in WR, RD_WAIT, RD_SEND or ACK: the byte is dropped and overrun pulses for one cycle.
REQ-031 The byte that completes a command is consumed and never reinterpreted as an opcode.
REQ-032 tx_valid is never deasserted, and tx_data never changes, until the handshake completes.

Reset
REQ-033 During rst=0: state=IDLE, address=0x0000, dout=0x00, read=1, tx_valid=0, tx_data=0x00, active=0, overrun=0; all counters cleared.
REQ-034 Reset mid-command aborts immediately. No write strobe is issued in the cycle after rst deasserts.

Verification
- Stream 0x57,0x12,0x34,0x01,0xAA,0xBB -> two one-cycle read=0 strobes, at 0x1234/0xAA and 0x1235/0xBB; then tx 0x4B; active falls after the ACK handshake.
- Memory preloaded 0x1234=0x5A, 0x1235=0xC3; stream 0x52,0x12,0x34,0x01 -> tx 0x5A then 0xC3; read stays 1 throughout.
- Read at 0xFFFF with N=1 and tx_ready held low 50 cycles -> tx_valid and tx_data=mem[0xFFFF] stable for 50 cycles; second byte is from 0x0000.
- Send 0x57,0x00 then nothing for RX_TIMEOUT cycles -> return to IDLE, active=0, no read=0 cycle; a following 0x52 command executes normally.
- Send 0x41 in IDLE -> ignored, no tx. An rx byte during RD_SEND -> one overrun pulse and the read data is unchanged.
- Assert rst=0 during WR of a 4-byte write -> next cycle state=IDLE, read=1, address=0x0000, tx_valid=0.
